cpu_decode_ctrl: RTL and testbench

- Instruction-decode control block for the LEGv8 pipelined CPU, sitting between instruction fetch and the execute stage.
- Decodes the 32-bit instruction into datapath control signals and the 3-bit ALU operation code.
- Produces the extended immediate and computes the PC-relative branch target using an internal 64-bit adder with carry/overflow.
- All outputs are registered, forming the ID/EX control register.

---
 rtl/cpu_decode_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_cpu_decode_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_decode_ctrl.sv
// LEGv8 instruction-decode control: turns an instruction into ID/EX control signals,
// the extended immediate and the PC-relative branch target. Every output is registered.
module cpu_decode_ctrl #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   instr,
    input  logic [DW-1:0] pc,
    output logic          uncondBr,
    output logic          branch,
    output logic          Reg2Loc,
    output logic          ALU_Src,
    output logic          RegWrite,
    output logic          ALU_SH,
    output logic          Imm,
    output logic          memToReg,
    output logic          memWrite,
    output logic          memRead,
    output logic          shiftDirn,
    output logic          set_flags,
    output logic          branchReg,
    output logic          branchLink,
    output logic [2:0]    ALU_cntrl,
    output logic [DW-1:0] imm64,
    output logic [DW-1:0] br_target,
    output logic          tgt_co,
    output logic          tgt_of,
    output logic          illegal
);

    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_BR   = 11'b11010110000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_BCND = 8'b01010100;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [5:0]  OP_BL   = 6'b100101;

    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_XOR   = 3'b110;

    // Add/sub adder with carry out in bit DW; sub inverts b and injects the carry-in.
    function automatic logic [DW:0] addsub(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b,
                                           input logic          sub);
        logic [DW-1:0] bx;
        bx = b ^ {DW{sub}};
        return {1'b0, a} + {1'b0, bx} + {{DW{1'b0}}, sub};
    endfunction

    logic [10:0]          opcode;
    logic                 uncondBr_p0, branch_p0, Reg2Loc_p0, ALU_Src_p0, RegWrite_p0;
    logic                 ALU_SH_p0, Imm_p0, memToReg_p0, memWrite_p0, memRead_p0;
    logic                 shiftDirn_p0, set_flags_p0, branchReg_p0, branchLink_p0;
    logic                 illegal_p0;
    logic [2:0]           ALU_cntrl_p0;
    logic signed [DW-1:0] imm_p0;
    logic signed [DW-1:0] off_p0;
    logic [DW:0]          sum_p0;
    logic                 of_p0;

    assign opcode = instr[31:21];

    always_comb begin
        uncondBr_p0   = 1'b0;
        branch_p0     = 1'b0;
        Reg2Loc_p0    = 1'b0;
        ALU_Src_p0    = 1'b0;
        RegWrite_p0   = 1'b0;
        ALU_SH_p0     = 1'b0;
        Imm_p0        = 1'b0;
        memToReg_p0   = 1'b0;
        memWrite_p0   = 1'b0;
        memRead_p0    = 1'b0;
        shiftDirn_p0  = 1'b0;
        set_flags_p0  = 1'b0;
        branchReg_p0  = 1'b0;
        branchLink_p0 = 1'b0;
        illegal_p0    = 1'b0;
        ALU_cntrl_p0  = ALU_PASSB;
        // Full 11-bit opcodes first, then the shorter prefixes from longest to shortest.
        case (opcode)
            OP_ADDS: begin
                RegWrite_p0  = 1'b1;
                Reg2Loc_p0   = 1'b1;
                set_flags_p0 = 1'b1;
                ALU_cntrl_p0 = ALU_ADD;
            end
            OP_SUBS: begin
                RegWrite_p0  = 1'b1;
                Reg2Loc_p0   = 1'b1;
                set_flags_p0 = 1'b1;
                ALU_cntrl_p0 = ALU_SUB;
            end
            OP_AND: begin
                RegWrite_p0  = 1'b1;
                Reg2Loc_p0   = 1'b1;
                ALU_cntrl_p0 = ALU_AND;
            end
            OP_EOR: begin
                RegWrite_p0  = 1'b1;
                Reg2Loc_p0   = 1'b1;
                ALU_cntrl_p0 = ALU_XOR;
            end
            OP_LSL: begin
                RegWrite_p0 = 1'b1;
                ALU_SH_p0   = 1'b1;
            end
            OP_LSR: begin
                RegWrite_p0  = 1'b1;
                ALU_SH_p0    = 1'b1;
                shiftDirn_p0 = 1'b1;
            end
            OP_LDUR: begin
                RegWrite_p0  = 1'b1;
                ALU_Src_p0   = 1'b1;
                memToReg_p0  = 1'b1;
                memRead_p0   = 1'b1;
                ALU_cntrl_p0 = ALU_ADD;
            end
            OP_STUR: begin
                ALU_Src_p0   = 1'b1;
                memWrite_p0  = 1'b1;
                ALU_cntrl_p0 = ALU_ADD;
            end
            OP_BR: begin
                branch_p0    = 1'b1;
                branchReg_p0 = 1'b1;
            end
            default: begin
                if (opcode[10:1] == OP_ADDI) begin
                    RegWrite_p0  = 1'b1;
                    ALU_Src_p0   = 1'b1;
                    Imm_p0       = 1'b1;
                    ALU_cntrl_p0 = ALU_ADD;
                end else if (opcode[10:3] == OP_CBZ) begin
                    branch_p0    = 1'b1;
                    ALU_cntrl_p0 = ALU_PASSB;
                end else if (opcode[10:3] == OP_BCND) begin
                    branch_p0 = 1'b1;
                end else if (opcode[10:5] == OP_B) begin
                    branch_p0   = 1'b1;
                    uncondBr_p0 = 1'b1;
                end else if (opcode[10:5] == OP_BL) begin
                    branch_p0     = 1'b1;
                    uncondBr_p0   = 1'b1;
                    branchLink_p0 = 1'b1;
                    RegWrite_p0   = 1'b1;
                end else begin
                    illegal_p0 = 1'b1;
                end
            end
        endcase
    end

    // ALU immediates are unsigned 12-bit; memory offsets are signed 9-bit.
    assign imm_p0 = Imm_p0 ? {{(DW-12){1'b0}}, instr[21:10]}
                           : {{(DW-9){instr[20]}}, instr[20:12]};

    // Word offsets scaled to bytes: 26-bit for B/BL, 19-bit for conditional forms.
    assign off_p0 = uncondBr_p0 ? {{(DW-28){instr[25]}}, instr[25:0], 2'b00}
                                : {{(DW-21){instr[23]}}, instr[23:5], 2'b00};

    assign sum_p0 = addsub(pc, off_p0, 1'b0);
    assign of_p0  = (pc[DW-1] == off_p0[DW-1]) && (sum_p0[DW-1] != pc[DW-1]);

    // ID/EX register boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uncondBr   <= 1'b0;
            branch     <= 1'b0;
            Reg2Loc    <= 1'b0;
            ALU_Src    <= 1'b0;
            RegWrite   <= 1'b0;
            ALU_SH     <= 1'b0;
            Imm        <= 1'b0;
            memToReg   <= 1'b0;
            memWrite   <= 1'b0;
            memRead    <= 1'b0;
            shiftDirn  <= 1'b0;
            set_flags  <= 1'b0;
            branchReg  <= 1'b0;
            branchLink <= 1'b0;
            ALU_cntrl  <= 3'b000;
            imm64      <= '0;
            br_target  <= '0;
            tgt_co     <= 1'b0;
            tgt_of     <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            uncondBr   <= uncondBr_p0;
            branch     <= branch_p0;
            Reg2Loc    <= Reg2Loc_p0;
            ALU_Src    <= ALU_Src_p0;
            RegWrite   <= RegWrite_p0;
            ALU_SH     <= ALU_SH_p0;
            Imm        <= Imm_p0;
            memToReg   <= memToReg_p0;
            memWrite   <= memWrite_p0;
            memRead    <= memRead_p0;
            shiftDirn  <= shiftDirn_p0;
            set_flags  <= set_flags_p0;
            branchReg  <= branchReg_p0;
            branchLink <= branchLink_p0;
            ALU_cntrl  <= ALU_cntrl_p0;
            imm64      <= imm_p0;
            br_target  <= sum_p0[DW-1:0];
            tgt_co     <= sum_p0[DW];
            tgt_of     <= of_p0;
            illegal    <= illegal_p0;
        end
    end

endmodule

// File: tb/tb_cpu_decode_ctrl.sv
// Bench for cpu_decode_ctrl: directed cases plus random instructions against a table-driven model.
module tb_cpu_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        uncondBr, branch, Reg2Loc, ALU_Src, RegWrite, ALU_SH, Imm, memToReg;
    logic        memWrite, memRead, shiftDirn, set_flags, branchReg, branchLink;
    logic [2:0]  ALU_cntrl;
    logic [63:0] imm64, br_target;
    logic        tgt_co, tgt_of, illegal;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    cpu_decode_ctrl #(.DW(64)) dut (
        .clk(clk), .rst(rst), .instr(instr), .pc(pc),
        .uncondBr(uncondBr), .branch(branch), .Reg2Loc(Reg2Loc), .ALU_Src(ALU_Src),
        .RegWrite(RegWrite), .ALU_SH(ALU_SH), .Imm(Imm), .memToReg(memToReg),
        .memWrite(memWrite), .memRead(memRead), .shiftDirn(shiftDirn),
        .set_flags(set_flags), .branchReg(branchReg), .branchLink(branchLink),
        .ALU_cntrl(ALU_cntrl), .imm64(imm64), .br_target(br_target),
        .tgt_co(tgt_co), .tgt_of(tgt_of), .illegal(illegal)
    );

    // ctrl bit order: uncondBr branch Reg2Loc ALU_Src RegWrite ALU_SH Imm memToReg
    //                 memWrite memRead shiftDirn set_flags branchReg branchLink
    typedef struct packed {
        logic [13:0] ctrl;
        logic [2:0]  alu;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        co;
        logic        of;
        logic        ill;
    } out_t;

    localparam logic [13:0] F_UB  = 14'h2000, F_BR  = 14'h1000, F_R2L = 14'h0800;
    localparam logic [13:0] F_SRC = 14'h0400, F_RW  = 14'h0200, F_SH  = 14'h0100;
    localparam logic [13:0] F_IMM = 14'h0080, F_M2R = 14'h0040, F_MW  = 14'h0020;
    localparam logic [13:0] F_MR  = 14'h0010, F_SD  = 14'h0008, F_SF  = 14'h0004;
    localparam logic [13:0] F_BRG = 14'h0002, F_BL  = 14'h0001;

    // Instruction table: prefix length, left-aligned opcode pattern, controls, ALU op.
    int          tlen[14] = '{11, 11, 11, 11, 11, 11, 11, 11, 11, 10, 8, 8, 6, 6};
    logic [10:0] tpat[14] = '{11'b10101011000, 11'b11101011000, 11'b10001010000,
                              11'b11001010000, 11'b11010011011, 11'b11010011010,
                              11'b11111000010, 11'b11111000000, 11'b11010110000,
                              11'b10010001000, 11'b10110100000, 11'b01010100000,
                              11'b00010100000, 11'b10010100000};
    logic [13:0] tctl[14] = '{F_RW|F_R2L|F_SF, F_RW|F_R2L|F_SF, F_RW|F_R2L, F_RW|F_R2L,
                              F_RW|F_SH, F_RW|F_SH|F_SD, F_RW|F_SRC|F_M2R|F_MR,
                              F_SRC|F_MW, F_BR|F_BRG, F_RW|F_SRC|F_IMM, F_BR, F_BR,
                              F_BR|F_UB, F_BR|F_UB|F_BL|F_RW};
    logic [2:0]  talu[14] = '{3'b010, 3'b011, 3'b100, 3'b110, 3'b000, 3'b000, 3'b010,
                              3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};

    out_t act;

    function automatic out_t model(input logic [31:0] ins, input logic [63:0] p);
        out_t        e;
        logic [10:0] m;
        logic        found;
        longint      s;
        longint      o;
        logic [63:0] o64;
        logic [64:0] full;
        e     = '0;
        found = 1'b0;
        for (int i = 0; i < 14; i++) begin
            m = 11'h7FF << (11 - tlen[i]);
            if (!found && ((ins[31:21] & m) == (tpat[i] & m))) begin
                found = 1'b1;
                e.ctrl = tctl[i];
                e.alu  = talu[i];
            end
        end
        e.ill = !found;
        if ((e.ctrl & F_IMM) != 0) begin
            e.imm = 64'(ins[21:10]);
        end else begin
            s = longint'(ins[20:12]);
            if (s >= 256) s = s - 512;
            e.imm = 64'(s);
        end
        if ((e.ctrl & F_UB) != 0) begin
            o = longint'(ins[25:0]);
            if (o >= (longint'(1) << 25)) o = o - (longint'(1) << 26);
        end else begin
            o = longint'(ins[23:5]);
            if (o >= (longint'(1) << 18)) o = o - (longint'(1) << 19);
        end
        o     = o * 4;
        o64   = 64'(o);
        full  = {1'b0, p} + {1'b0, o64};
        e.tgt = full[63:0];
        e.co  = full[64];
        e.of  = ($signed(p) >= 0 && o >= 0 && $signed(e.tgt) < 0) ||
                ($signed(p) < 0 && o < 0 && $signed(e.tgt) >= 0);
        return e;
    endfunction

    function automatic out_t get_act();
        return {uncondBr, branch, Reg2Loc, ALU_Src, RegWrite, ALU_SH, Imm, memToReg,
                memWrite, memRead, shiftDirn, set_flags, branchReg, branchLink,
                ALU_cntrl, imm64, br_target, tgt_co, tgt_of, illegal};
    endfunction

    task automatic apply(input logic [31:0] i, input logic [63:0] p);
        @(negedge clk);
        instr = i;
        pc    = p;
        @(posedge clk);
        #1;
        act = get_act();
    endtask

    task automatic test_reset();
        out_t e;
        rst   = 1'b1;
        instr = 32'h91001401;
        pc    = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        act = get_act();
        total++;
        if (act !== '0) $display("FAIL reset_hold: got %h expected 0", act); else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        act = get_act();
        e   = model(32'h91001401, 64'h0);
        total++;
        if (act !== e) $display("FAIL reset_release: got %h expected %h", act, e); else passed++;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        act = get_act();
        total++;
        if (act !== '0) $display("FAIL reset_async: got %h expected 0", act); else passed++;
        @(posedge clk);
        #1;
        act = get_act();
        total++;
        if (act !== '0) $display("FAIL reset_held: got %h expected 0", act); else passed++;
        @(negedge clk);
        rst   = 1'b0;
        instr = 32'hEB020020;
        pc    = 64'h40;
        @(posedge clk);
        #1;
        act = get_act();
        e   = model(32'hEB020020, 64'h40);
        total++;
        if (act !== e) $display("FAIL reset_first_word: got %h expected %h", act, e); else passed++;
    endtask

    task automatic test_addi();
        apply(32'h91001401, 64'h0);
        total++;
        if ({RegWrite, ALU_Src, Imm, ALU_cntrl, imm64, illegal} !== {3'b111, 3'b010, 64'd5, 1'b0})
            $display("FAIL addi_fields: got %b%b%b %b %h %b required 111 010 5 0",
                     RegWrite, ALU_Src, Imm, ALU_cntrl, imm64, illegal);
        else passed++;
        total++;
        if (act !== model(32'h91001401, 64'h0))
            $display("FAIL addi_word: got %h expected %h", act, model(32'h91001401, 64'h0));
        else passed++;
    endtask

    task automatic test_subs();
        logic [31:0] i;
        i = {11'b11101011000, 21'($urandom)};
        apply(i, 64'h1000);
        total++;
        if ({RegWrite, Reg2Loc, set_flags, ALU_cntrl} !== 6'b111011)
            $display("FAIL subs_fields: got %b required 111011",
                     {RegWrite, Reg2Loc, set_flags, ALU_cntrl});
        else passed++;
        total++;
        if (act !== model(i, 64'h1000))
            $display("FAIL subs_word: got %h expected %h", act, model(i, 64'h1000));
        else passed++;
    endtask

    task automatic test_ldur_stur();
        logic [31:0] i;
        i = {11'b11111000010, 9'h1F8, 2'b00, 5'd3, 5'd4};
        apply(i, 64'h200);
        total++;
        if ({imm64, memRead, memToReg, ALU_cntrl} !== {64'hFFFF_FFFF_FFFF_FFF8, 2'b11, 3'b010})
            $display("FAIL ldur_fields: got %h %b%b %b required fffffffffffffff8 11 010",
                     imm64, memRead, memToReg, ALU_cntrl);
        else passed++;
        total++;
        if (act !== model(i, 64'h200))
            $display("FAIL ldur_word: got %h expected %h", act, model(i, 64'h200));
        else passed++;
        i = {11'b11111000000, 9'h010, 2'b00, 5'd3, 5'd4};
        apply(i, 64'h204);
        total++;
        if ({memWrite, RegWrite} !== 2'b10)
            $display("FAIL stur_fields: got %b%b required 10", memWrite, RegWrite);
        else passed++;
        total++;
        if (act !== model(i, 64'h204))
            $display("FAIL stur_word: got %h expected %h", act, model(i, 64'h204));
        else passed++;
    endtask

    task automatic test_branches();
        logic [31:0] i;
        i = {6'b000101, 26'h3FFFFFF};
        apply(i, 64'h100);
        total++;
        if ({br_target, tgt_co, tgt_of, uncondBr, branch} !== {64'hFC, 4'b1011})
            $display("FAIL b_target: got %h %b%b%b%b required fc 1011",
                     br_target, tgt_co, tgt_of, uncondBr, branch);
        else passed++;
        i = {6'b100101, 26'($urandom)};
        apply(i, 64'h3000);
        total++;
        if ({branchLink, RegWrite} !== 2'b11)
            $display("FAIL bl_fields: got %b%b required 11", branchLink, RegWrite);
        else passed++;
        total++;
        if (act !== model(i, 64'h3000))
            $display("FAIL bl_word: got %h expected %h", act, model(i, 64'h3000));
        else passed++;
        i = {8'b10110100, 19'd2, 5'd7};
        apply(i, 64'h10);
        total++;
        if ({br_target, ALU_cntrl, branch} !== {64'h18, 3'b000, 1'b1})
            $display("FAIL cbz_target: got %h %b %b required 18 000 1", br_target, ALU_cntrl, branch);
        else passed++;
        i = {8'b01010100, 19'd1, 5'd0};
        apply(i, 64'h7FFF_FFFF_FFFF_FFFC);
        total++;
        if ({br_target, tgt_of} !== {64'h8000_0000_0000_0000, 1'b1})
            $display("FAIL bcond_overflow: got %h %b required 8000000000000000 1", br_target, tgt_of);
        else passed++;
        total++;
        if (act !== model(i, 64'h7FFF_FFFF_FFFF_FFFC))
            $display("FAIL bcond_word: got %h expected %h", act, model(i, 64'h7FFF_FFFF_FFFF_FFFC));
        else passed++;
    endtask

    task automatic test_illegal();
        apply(32'h0000_0000, 64'h80);
        total++;
        if ({act.ctrl, act.alu, act.ill} !== {17'b0, 1'b1})
            $display("FAIL illegal_fields: got %h %b %b required 0 000 1", act.ctrl, act.alu, act.ill);
        else passed++;
        total++;
        if (act !== model(32'h0000_0000, 64'h80))
            $display("FAIL illegal_word: got %h expected %h", act, model(32'h0000_0000, 64'h80));
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] i;
        logic [63:0] p;
        logic [31:0] m32;
        int          k;
        out_t        e;
        for (int n = 0; n < 300; n++) begin
            i = $urandom;
            k = $urandom_range(0, 15);
            if (k < 14) begin
                m32 = {11'h7FF << (11 - tlen[k]), 21'b0};
                i   = (i & ~m32) | ({tpat[k], 21'b0} & m32);
            end
            case ($urandom_range(0, 3))
                0:       p = {$urandom, $urandom};
                1:       p = 64'h7FFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
                2:       p = 64'($urandom_range(0, 255));
                default: p = 64'h8000_0000_0000_0000 | 64'($urandom_range(0, 255));
            endcase
            apply(i, p);
            e = model(i, p);
            total++;
            if (act !== e)
                $display("FAIL random_%0d instr=%h pc=%h: got %h expected %h", n, i, p, act, e);
            else passed++;
        end
    endtask

    initial begin
        rst   = 1'b1;
        instr = '0;
        pc    = '0;
        test_reset();
        test_addi();
        test_subs();
        test_ldur_stur();
        test_branches();
        test_illegal();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
